shake_squeeze_stream: RTL and testbench
=======================================

# shake_squeeze_stream

Squeeze-side reader for the Keccak sponge. It takes a fully absorbed 1600-bit state from an absorb front end and streams the rate portion out as fixed-width words over a valid/ready interface. When the rate block is exhausted and more words are owed, it asks the shared Keccak-p responder for another permutation. It sits between the hash front ends and the Kyber samplers (matrix expansion, CBD), which pull XOF output at their own pace.

## Interface
Parameters:
- RATE_BITS, 1344: sponge rate r. Use 1344 for SHAKE-128 and 1088 for SHAKE-256. Must be a multiple of WORD_W.
- WORD_W, 64: output word width.
- CNT_W, 16: width of the requested-word counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; loads state_in and req_words
- state_in  in  [0:1599]  absorbed sponge state, bit 0 first
- req_words  in  CNT_W  number of words to emit
- out_word  out  WORD_W  current output word
- out_valid  out  1  out_word is valid
- out_ready  in  1  consumer accepts out_word
- perm_req  out  1  permutation request to the Keccak-p responder
- perm_state_out  out  [0:1599]  state sent with perm_req
- perm_ack  in  1  one-cycle pulse; perm_state_in is valid
- perm_state_in  in  [0:1599]  permuted state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Word k of the current block is state[k*WORD_W +: WORD_W], k = 0 .. RATE_BITS/WORD_W-1. Bits beyond RATE_BITS are never emitted.
- The FSM has four states: IDLE, EMIT, PERM, DONE.
- IDLE:
  - start latches state_in into the state register, loads remaining = req_words and sets idx = 0.
  - If req_words = 0, go to DONE. Otherwise go to EMIT.
- EMIT:
  - out_valid = 1 and out_word = word idx.
  - On out_valid & out_ready: remaining decrements and idx increments.
  - If the new remaining = 0, go to DONE.
  - Else if the accepted word was the last word of the rate (idx = RATE_BITS/WORD_W-1), set idx = 0 and go to PERM.
- PERM:
  - perm_req = 1 and perm_state_out = state register, both held stable until perm_ack.
  - On perm_ack: load perm_state_in into the state register and go to EMIT.
- DONE: done = 1 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE.
- perm_ack outside PERM is ignored.
- out_word is forced to 0 whenever out_valid = 0.
- Counter arithmetic: remaining is CNT_W bits and never underflows; idx is clog2(RATE_BITS/WORD_W) bits.
- Reset mid-operation returns the FSM to IDLE immediately. An outstanding permutation request is dropped; the responder must tolerate perm_req falling without an ack.

## Timing
- Reset values: out_valid 0, out_word 0, perm_req 0, perm_state_out 0, busy 0, done 0, state register 0, remaining 0, idx 0.
- start sampled in cycle n: out_valid = 1 in cycle n+1.
- A word is accepted in cycle t and the next word is in the same block: the next word is presented in cycle t+1. Throughput is one word per cycle while out_ready stays high.
- The last rate word is accepted in cycle t with words still owed: perm_req = 1 from cycle t+1.
- perm_ack in cycle a: perm_req = 0 and out_valid = 1 (word 0 of the new block) in cycle a+1.
- Final word accepted in cycle t: done = 1 in cycle t+1, busy = 0 in cycle t+2.
- Consumer stall: out_word must stay stable while out_valid = 1 and out_ready = 0.
- start with req_words = 0 in cycle n: done = 1 in cycle n+1, and out_valid never rises.

## Configuration
- SQUEEZE_ABORT_EN
- Defined:
  - Adds input abort (1 bit).
  - In EMIT or DONE, abort moves the FSM to IDLE on the next edge without a done pulse.
  - In PERM, the abort is remembered and the FSM goes to IDLE on the cycle after perm_ack; the acknowledged state is discarded.
  - abort in IDLE has no effect.
- Not defined: no abort port; a transfer always runs to done.

## Structure
- Shared package kyber_hash_pkg holds:
  - KECCAK_B = 1600
  - RATE_SHAKE128 = 1344, RATE_SHAKE256 = 1088
  - the squeeze FSM state encoding (IDLE/EMIT/PERM/DONE)
- No sub-module. The word select is an indexed part-select on the state register.

## Test plan
- SHAKE-128, state_in with each 64-bit word k = k, req_words = 3, out_ready = 1 -> words 0, 1, 2 in consecutive cycles starting at start+1; done at start+4; perm_req never asserted.
- req_words = 23 with RATE_BITS = 1344 -> after 21 words perm_req rises. The responder returns a state with word k = 0x100+k and acks 5 cycles later. The cycle after the ack shows out_word 0x100, then 0x101; done follows the 23rd word.
- out_ready toggles 1,0,0,1 during EMIT -> out_word stays stable through the stall and no word is duplicated or skipped.
- req_words = 0 -> done one cycle after start, out_valid stays 0.
- rst asserted in PERM -> perm_req and busy are 0 immediately; a subsequent start with req_words = 1 emits word 0 of the new state_in.
- With SQUEEZE_ABORT_EN: abort during PERM, ack 3 cycles later -> IDLE the cycle after the ack, no done pulse, no further out_valid.

Source files
------------

// File: rtl/kyber_hash_pkg.sv
// Keccak/SHAKE constants shared by the Kyber hash blocks, plus the squeeze FSM
// state encoding.
package kyber_hash_pkg;

    localparam int unsigned KECCAK_B      = 1600;
    localparam int unsigned RATE_SHAKE128 = 1344;
    localparam int unsigned RATE_SHAKE256 = 1088;

    localparam logic [1:0] SQ_IDLE = 2'd0;
    localparam logic [1:0] SQ_EMIT = 2'd1;
    localparam logic [1:0] SQ_PERM = 2'd2;
    localparam logic [1:0] SQ_DONE = 2'd3;

endpackage

// File: rtl/shake_squeeze_stream_if.sv
// Squeeze output stream plus the request/ack channel to the shared Keccak-p
// responder. The master side is the squeeze reader.
interface shake_squeeze_stream_if #(
    parameter int unsigned WORD_W = 64
) ();
    import kyber_hash_pkg::*;

    logic [WORD_W-1:0]   out_word;
    logic                out_valid;
    logic                out_ready;
    logic                perm_req;
    logic [0:KECCAK_B-1] perm_state_out;
    logic                perm_ack;
    logic [0:KECCAK_B-1] perm_state_in;

    modport master (
        output out_word, out_valid, perm_req, perm_state_out,
        input  out_ready, perm_ack, perm_state_in
    );

    modport slave (
        input  out_word, out_valid, perm_req, perm_state_out,
        output out_ready, perm_ack, perm_state_in
    );

endinterface

// File: rtl/shake_squeeze_stream.sv
// SHAKE squeeze reader: streams rate words of an absorbed state, requesting a
// permutation per exhausted block. SQUEEZE_ABORT_EN adds an abort input.
module shake_squeeze_stream
    import kyber_hash_pkg::*;
#(
    parameter int unsigned RATE_BITS = RATE_SHAKE128,
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [0:KECCAK_B-1]    state_in,
    input  logic [CNT_W-1:0]       req_words,
`ifdef SQUEEZE_ABORT_EN
    input  logic                   abort,
`endif
    shake_squeeze_stream_if.master bus,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned NWORDS = RATE_BITS / WORD_W;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BASE_W = $clog2(KECCAK_B);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [1:0]          r_fsm;
    logic [0:KECCAK_B-1] r_state;
    logic [CNT_W-1:0]    r_remaining;
    logic [IDX_W-1:0]    r_idx;
    logic                r_abort_pend;

    logic                w_emit;
    logic                w_perm;
    logic                w_accept;
    logic                w_last_word;
    logic                w_abort;
    logic [BASE_W-1:0]   w_base;

`ifdef SQUEEZE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_emit      = (r_fsm == SQ_EMIT);
    assign w_perm      = (r_fsm == SQ_PERM);
    assign w_accept    = w_emit && bus.out_ready;
    assign w_last_word = (r_idx == LAST_IDX);
    assign w_base      = BASE_W'(r_idx) * BASE_W'(WORD_W);

    assign bus.out_valid      = w_emit;
    assign bus.out_word       = w_emit ? r_state[w_base +: WORD_W] : '0;
    assign bus.perm_req       = w_perm;
    assign bus.perm_state_out = w_perm ? r_state : '0;

    assign busy = (r_fsm != SQ_IDLE);
    assign done = (r_fsm == SQ_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= SQ_IDLE;
            r_state      <= '0;
            r_remaining  <= '0;
            r_idx        <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_fsm)
                SQ_IDLE: begin
                    r_abort_pend <= 1'b0;
                    if (start) begin
                        r_state     <= state_in;
                        r_remaining <= req_words;
                        r_idx       <= '0;
                        r_fsm       <= (req_words == '0) ? SQ_DONE : SQ_EMIT;
                    end
                end
                SQ_EMIT: begin
                    if (w_abort) begin
                        r_fsm <= SQ_IDLE;
                    end else if (w_accept) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_idx       <= w_last_word ? '0 : r_idx + IDX_W'(1);
                        if (r_remaining == CNT_W'(1))
                            r_fsm <= SQ_DONE;
                        else if (w_last_word)
                            r_fsm <= SQ_PERM;
                    end
                end
                SQ_PERM: begin
                    // An abort seen while waiting is held until the responder
                    // acks, so the request is never withdrawn mid-flight.
                    if (bus.perm_ack) begin
                        r_abort_pend <= 1'b0;
                        if (r_abort_pend || w_abort) begin
                            r_fsm <= SQ_IDLE;
                        end else begin
                            r_state <= bus.perm_state_in;
                            r_fsm   <= SQ_EMIT;
                        end
                    end else if (w_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                default: r_fsm <= SQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_squeeze_stream.sv
// Scoreboard bench for shake_squeeze_stream (SHAKE-128, 64-bit words); runs the
// abort scenario when SQUEEZE_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_shake_squeeze_stream;
    import kyber_hash_pkg::*;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RATE   = RATE_SHAKE128;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [0:KECCAK_B-1] state_in;
    logic [CNT_W-1:0]    req_words;
`ifdef SQUEEZE_ABORT_EN
    logic                abort;
`endif
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] exp_q[$];

    shake_squeeze_stream_if #(.WORD_W(WORD_W)) bus ();

    shake_squeeze_stream #(.RATE_BITS(RATE), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .req_words (req_words),
`ifdef SQUEEZE_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [0:KECCAK_B-1] mk_state(input logic [WORD_W-1:0] base);
        logic [0:KECCAK_B-1] s;
        for (int k = 0; k < KECCAK_B / WORD_W; k++)
            s[k*WORD_W +: WORD_W] = base + WORD_W'(k);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in the window of cycle start+1.
    task automatic do_start(input logic [0:KECCAK_B-1] st, input logic [CNT_W-1:0] n);
        state_in  = st;
        req_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; req_words = '0; state_in = '0;
        bus.out_ready = 1'b0; bus.perm_ack = 1'b0; bus.perm_state_in = '0;
`ifdef SQUEEZE_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_word !== '0) begin errors++; $display("FAIL rst_out_word: got %h expected 0", bus.out_word); end
        checks++; if (bus.perm_req !== 1'b0) begin errors++; $display("FAIL rst_perm_req: got %b expected 0", bus.perm_req); end
        checks++; if (bus.perm_state_out !== '0) begin errors++; $display("FAIL rst_perm_state_out: word0 got %h expected 0", bus.perm_state_out[0:63]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int n = 0;
        int done_cyc = 0;
        logic [WORD_W-1:0] exp;
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(WORD_W'(k));
        bus.out_ready = 1'b1;
        do_start(mk_state('0), 16'd3);
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            checks++; if (bus.perm_req !== 1'b0) begin errors++; $display("FAIL basic_perm_req: cycle %0d got %b expected 0", c, bus.perm_req); end
            if (bus.out_valid === 1'b1) begin
                checks++; if (c != n + 1) begin errors++; $display("FAIL basic_word_cycle: got cycle %0d expected %0d", c, n + 1); end
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL basic_extra_word: got %h expected none", bus.out_word);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (bus.out_word !== exp) begin errors++; $display("FAIL basic_word: got %h expected %h", bus.out_word, exp); end
                end
                n++;
            end
            if (done === 1'b1) done_cyc = c; else tick();
        end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 4", done_cyc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_words_left: got %0d expected 0", exp_q.size()); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_perm();
        int n = 0;
        int p_cyc = 0;
        int ack_cyc = 0;
        int done_cyc = 0;
        logic [WORD_W-1:0] exp;
        logic [0:KECCAK_B-1] st_a;
        logic [0:KECCAK_B-1] st_b;
        st_a = mk_state(64'h0);
        st_b = mk_state(64'h100);
        exp_q.delete();
        for (int k = 0; k < 21; k++) exp_q.push_back(WORD_W'(k));
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h101);
        bus.out_ready = 1'b1;
        do_start(st_a, 16'd23);
        for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
            bus.perm_ack = 1'b0;
            if (ack_cyc != 0 && c == ack_cyc + 1) begin
                checks++; if (bus.perm_req !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL perm_resume: got req=%b valid=%b expected req=0 valid=1", bus.perm_req, bus.out_valid); end
            end
            if (bus.perm_req === 1'b1) begin
                if (p_cyc == 0) p_cyc = c;
                checks++; if (bus.perm_state_out !== st_a) begin errors++; $display("FAIL perm_state_out: word0 got %h expected %h", bus.perm_state_out[0:63], st_a[0:63]); end
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL perm_out_valid: got %b expected 0", bus.out_valid); end
                if (c == p_cyc + 5) begin
                    bus.perm_ack = 1'b1;
                    bus.perm_state_in = st_b;
                    ack_cyc = c;
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL perm_extra_word: got %h expected none", bus.out_word);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (bus.out_word !== exp) begin errors++; $display("FAIL perm_word: cycle %0d got %h expected %h", c, bus.out_word, exp); end
                end
                n++;
            end
            if (done === 1'b1) done_cyc = c; else tick();
        end
        bus.perm_ack = 1'b0;
        checks++; if (p_cyc != 22) begin errors++; $display("FAIL perm_req_cycle: got %0d expected 22", p_cyc); end
        checks++; if (done_cyc != 30) begin errors++; $display("FAIL perm_done_cycle: got %0d expected 30", done_cyc); end
        checks++; if (n != 23) begin errors++; $display("FAIL perm_word_count: got %0d expected 23", n); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perm_busy_after: got %b expected 0", busy); end
    endtask

    // Stall with ready 1,0,0,1; a stray start and perm_ack land mid-transfer.
    task automatic test_stall();
        int n = 0;
        int done_cyc = 0;
        logic stalled = 1'b0;
        logic [WORD_W-1:0] last_word = '0;
        logic [WORD_W-1:0] exp;
        logic pat [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(64'h200 + WORD_W'(k));
        bus.out_ready = 1'b1;
        do_start(mk_state(64'h200), 16'd4);
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            start = (c == 2);
            if (c == 2) begin state_in = mk_state(64'h900); req_words = 16'd9; end
            bus.perm_ack = (c == 3);
            bus.perm_state_in = mk_state(64'hA00);
            bus.out_ready = (c <= 8) ? pat[c-1] : 1'b1;
            if (bus.out_valid === 1'b1) begin
                if (stalled) begin
                    checks++; if (bus.out_word !== last_word) begin errors++; $display("FAIL stall_stable: got %h expected %h", bus.out_word, last_word); end
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL stall_extra_word: got %h expected none", bus.out_word);
                end else if (bus.out_ready) begin
                    exp = exp_q.pop_front();
                    checks++; if (bus.out_word !== exp) begin errors++; $display("FAIL stall_word: got %h expected %h", bus.out_word, exp); end
                    n++;
                end else begin
                    checks++; if (bus.out_word !== exp_q[0]) begin errors++; $display("FAIL stall_held_word: got %h expected %h", bus.out_word, exp_q[0]); end
                end
                last_word = bus.out_word;
                stalled = !bus.out_ready;
            end
            if (done === 1'b1) done_cyc = c; else tick();
        end
        start = 1'b0;
        bus.perm_ack = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 7", done_cyc); end
        checks++; if (n != 4) begin errors++; $display("FAIL stall_word_count: got %0d expected 4", n); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        do_start(mk_state(64'h500), 16'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", bus.out_valid); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b done=%b expected 0 0", busy, done); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_late: got %b expected 0", bus.out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_in_perm();
        int c = 0;
        logic [WORD_W-1:0] exp;
        bus.out_ready = 1'b1;
        do_start(mk_state(64'h300), 16'd25);
        while (bus.perm_req !== 1'b1 && c < 40) begin tick(); c++; end
        checks++; if (bus.perm_req !== 1'b1) begin errors++; $display("FAIL rperm_reach: got perm_req=%b expected 1", bus.perm_req); end
        rst = 1'b1;
        #1;
        checks++; if (bus.perm_req !== 1'b0) begin errors++; $display("FAIL rperm_req: got %b expected 0", bus.perm_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rperm_busy: got %b expected 0", busy); end
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        exp_q.push_back(64'h400);
        do_start(mk_state(64'h400), 16'd1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rperm_valid: got %b expected 1", bus.out_valid); end
        exp = exp_q.pop_front();
        checks++; if (bus.out_word !== exp) begin errors++; $display("FAIL rperm_word: got %h expected %h", bus.out_word, exp); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rperm_done: got %b expected 1", done); end
        tick();
    endtask

`ifdef SQUEEZE_ABORT_EN
    task automatic test_abort();
        int p_cyc = 0;
        int ack_cyc = 0;
        logic [WORD_W-1:0] exp;
        exp_q.delete();
        for (int k = 0; k < 21; k++) exp_q.push_back(WORD_W'(k));
        bus.out_ready = 1'b1;
        do_start(mk_state(64'h0), 16'd23);
        for (int c = 1; c <= 60; c++) begin
            abort = 1'b0;
            bus.perm_ack = 1'b0;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: cycle %0d got %b expected 0", c, done); end
            if (ack_cyc != 0) begin
                if (c == ack_cyc + 1) begin
                    checks++; if (busy !== 1'b0 || bus.perm_req !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b req=%b expected 0 0", busy, bus.perm_req); end
                end
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: cycle %0d got %b expected 0", c, bus.out_valid); end
                if (c == ack_cyc + 6) break;
            end else begin
                if (bus.perm_req === 1'b1 && p_cyc == 0) begin p_cyc = c; abort = 1'b1; end
                if (p_cyc != 0 && c == p_cyc + 3) begin
                    bus.perm_ack = 1'b1;
                    bus.perm_state_in = mk_state(64'h100);
                    ack_cyc = c;
                end
                if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    checks++; if (bus.out_word !== exp) begin errors++; $display("FAIL abort_word: got %h expected %h", bus.out_word, exp); end
                end
            end
            tick();
        end
        abort = 1'b0;
        bus.perm_ack = 1'b0;
        checks++; if (ack_cyc == 0) begin errors++; $display("FAIL abort_no_perm: got no perm_req expected one"); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_perm();
        test_stall();
        test_zero();
        test_reset_in_perm();
`ifdef SQUEEZE_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
